seg_display_scanner: RTL and testbench
======================================

# seg_display_scanner

Time-multiplexed scan controller for the hex seven-segment display. It latches a multi-digit hex value and scans the digits one per refresh slot. Each slot drives the 4-bit nibble into the downstream hex-to-7-segment decoder and asserts that digit's active-low enable. Updates are tear-free, digit enables include anti-ghosting dead time, and leading-zero blanking is optional. It sits between the CPU-side debug/bus-monitor registers and the nibble decoder feeding the board display.

## Interface
- NUM_DIGITS, 4: number of display digits (1..8).
- REFRESH_DIV, 50000: clock cycles per digit slot (≥ DEAD_CYCLES+2).
- DEAD_CYCLES, 500: cycles at the start of each slot with all digits off (≥ 1).
- LZB_EN, 1: 1 enables leading-zero blanking.

- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- value  in  4*NUM_DIGITS  value to display; nibble i is digit i (i=0 rightmost, least significant).
- load  in  1  one-cycle strobe; samples value into the shadow register.
- nibble  out  4  current digit's nibble, to the decoder input.
- digit_en_n  out  NUM_DIGITS  active-low digit enables; at most one low at any time.
- frame_start  out  1  one-cycle pulse when digit 0's slot begins.

## Operation
- Prescaler: slot_cnt counts 0..REFRESH_DIV-1 and then wraps. The cycle where slot_cnt == REFRESH_DIV-1 is a slot tick.
- Digit index: idx advances on each slot tick. When NUM_DIGITS-1 advances it wraps to 0.
- Shadow register: on load, shadow <= value and pending <= 1.
- Display register: updates only at a frame boundary, which is a slot tick with idx == NUM_DIGITS-1.
  - At that boundary, if pending, disp <= shadow and pending <= 0.
  - If load coincides with the boundary, the new value goes to shadow and pending stays 1. disp takes the old shadow, and the new value commits at the next frame.
  - The display therefore never shows a mix of two values.
- nibble: registered, = disp[4*idx +: 4]. Updates the cycle after idx changes.
- Blanking (LZB_EN=1): digit i>0 is blanked when disp nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never blanked. A blanked digit keeps digit_en_n high for its whole slot.
- digit_en_n[idx] is low while slot_cnt ≥ DEAD_CYCLES and the digit is not blanked. Every other bit is high.
- frame_start: high for the one cycle after the slot tick that sets idx to 0.
- Reset: slot_cnt=0, idx=0, shadow=0, disp=0, pending=0, nibble=0, digit_en_n all ones, frame_start=0.
  - Reset asserted mid-slot or mid-frame abandons the frame. Any pending load is discarded.
  - After rst_n deasserts, the first slot is digit 0 starting at slot_cnt=0. frame_start is not pulsed for this first frame.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- load at cycle t: shadow is valid at t+1. disp changes at the next frame-boundary tick, at most NUM_DIGITS*REFRESH_DIV cycles later.
- Per slot of REFRESH_DIV cycles:
  - slot_cnt 0..DEAD_CYCLES-1: all enables high.
  - Remaining REFRESH_DIV-DEAD_CYCLES cycles: one enable low.
  - nibble is stable before the enable drops and stays stable until after it rises.
- Frame period = NUM_DIGITS*REFRESH_DIV cycles.
- Back-to-back load strobes within one frame: the last one wins.

## Structure
- The shared package seg_display_pkg holds:
  - the digit-count limit (MAX_DIGITS=8);
  - the nibble typedef (logic [3:0]);
  - the all-off enable constant.
- One sub-module, scan_tick_gen: the REFRESH_DIV prescaler emitting slot_cnt and the slot tick. The top level holds idx, the shadow/display registers, blanking and the output registers.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2, LZB_EN=1.
- Reset: hold rst_n low for 3 cycles, release → digit_en_n=4'b1111 and nibble=0. Digit 0 enables at cycle 2 of the first slot. Digits 1-3 stay blanked because disp=0.
- Scan: load value=16'h1234 and wait one frame → nibble sequence 4,3,2,1. digit_en_n goes 1110,1101,1011,0111, each low for 6 cycles preceded by 2 cycles of 1111. frame_start pulses every 32 cycles.
- Tear-free: load 16'hABCD mid-frame while 16'h1234 is displayed → the rest of the frame still shows 1234. The next frame shows D,C,B,A.
- Boundary collision: load 16'h5555 exactly on the frame-boundary tick while pending=1 with 16'h1111 → the next frame shows 1111 and the following frame shows 5555.
- Blanking: load 16'h0070 → digits 0 and 1 are lit (0, 7). Digits 2 and 3 keep digit_en_n high for their full slots. Load 16'h0000 → only digit 0 is lit, showing 0.
- Reset mid-operation: assert rst_n low during digit 2's slot with a pending load → all outputs return to reset values. After release, disp=0 and the pending value is never shown.

Source files
------------

// File: rtl/seg_display_pkg.sv
// Shared constants and types for the seven-segment scan controller.
package seg_display_pkg;

    localparam int unsigned MAX_DIGITS = 8;
    localparam int unsigned NIBBLE_W   = 4;

    typedef logic [NIBBLE_W-1:0] nibble_t;

    // Active-low enables: every digit dark.
    localparam logic [MAX_DIGITS-1:0] ALL_OFF = '1;

endpackage

// File: rtl/scan_tick_gen.sv
// Slot prescaler: counts 0..REFRESH_DIV-1 and flags the last cycle of each slot.
module scan_tick_gen #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned CNT_W       = $clog2(REFRESH_DIV)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] slot_cnt,
    output logic             tick_c
);

    // Last cycle of the current slot.
    assign tick_c = (slot_cnt == CNT_W'(REFRESH_DIV - 1));

    // Free-running slot counter, wrapping on the tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_cnt <= '0;
        end else if (tick_c) begin
            slot_cnt <= '0;
        end else begin
            slot_cnt <= slot_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seg_display_scanner.sv
// Time-multiplexed hex display scanner with tear-free frame updates,
// anti-ghosting dead time and optional leading-zero blanking.
module seg_display_scanner
    import seg_display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned DEAD_CYCLES = 500,
    parameter int unsigned LZB_EN      = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] value,
    input  logic                           load,
    output nibble_t                        nibble,
    output logic [NUM_DIGITS-1:0]          digit_en_n,
    output logic                           frame_start
);

    localparam int unsigned CNT_W    = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned LAST_IDX = NUM_DIGITS - 1;

    if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
        $error("seg_display_scanner: NUM_DIGITS out of range");
    end

    logic [CNT_W-1:0]            slot_cnt;
    logic                        tick_c;
    logic                        boundary_c;
    logic [IDX_W-1:0]            idx;
    logic [IDX_W-1:0]            idx_nxt;
    nibble_t [NUM_DIGITS-1:0]    shadow;
    nibble_t [NUM_DIGITS-1:0]    disp;
    nibble_t [NUM_DIGITS-1:0]    disp_nxt;
    logic                        pending;
    logic                        pending_nxt;
    logic                        lit_c;
    logic [NUM_DIGITS-1:0]       en_nxt;

    scan_tick_gen #(
        .REFRESH_DIV (REFRESH_DIV),
        .CNT_W       (CNT_W)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .slot_cnt (slot_cnt),
        .tick_c   (tick_c)
    );

    // A frame ends on the tick of the last digit's slot.
    assign boundary_c = tick_c && (idx == IDX_W'(LAST_IDX));

    // Digit index advances once per slot and wraps after the last digit.
    always_comb begin
        idx_nxt = idx;
        if (tick_c) begin
            idx_nxt = boundary_c ? '0 : idx + IDX_W'(1);
        end
    end

    // Commit the shadow only at a frame boundary; a coinciding load stays pending.
    always_comb begin
        disp_nxt    = disp;
        pending_nxt = pending;
        if (boundary_c && pending) begin
            disp_nxt    = shadow;
            pending_nxt = 1'b0;
        end
        if (load) begin
            pending_nxt = 1'b1;
        end
    end

    // Upcoming digit is lit unless it and every more significant nibble are zero.
    always_comb begin
        lit_c = 1'b1;
        if (LZB_EN != 0 && idx_nxt != '0) begin
            lit_c = 1'b0;
            for (int i = 1; i < NUM_DIGITS; i++) begin
                if (IDX_W'(i) >= idx_nxt && disp_nxt[i] != '0) begin
                    lit_c = 1'b1;
                end
            end
        end
    end

    // Enables follow the upcoming counter value so the dead window starts at slot_cnt 0.
    always_comb begin
        en_nxt = ALL_OFF[NUM_DIGITS-1:0];
        if (!tick_c && slot_cnt >= CNT_W'(DEAD_CYCLES - 1) && lit_c) begin
            en_nxt[idx_nxt] = 1'b0;
        end
    end

    // Scan state and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx         <= '0;
            shadow      <= '0;
            disp        <= '0;
            pending     <= 1'b0;
            nibble      <= '0;
            digit_en_n  <= ALL_OFF[NUM_DIGITS-1:0];
            frame_start <= 1'b0;
        end else begin
            idx         <= idx_nxt;
            if (load) begin
                shadow <= value;
            end
            disp        <= disp_nxt;
            pending     <= pending_nxt;
            nibble      <= disp[idx];
            digit_en_n  <= en_nxt;
            frame_start <= boundary_c;
        end
    end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Scoreboard bench for seg_display_scanner against a cycle/frame arithmetic model.
module tb_seg_display_scanner;

    localparam int N  = 4;
    localparam int R  = 8;
    localparam int D  = 2;
    localparam int NR = N * R;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  nibble;
    logic [3:0]  digit_en_n;
    logic        frame_start;

    always #5 clk = ~clk;

    seg_display_scanner #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (R),
        .DEAD_CYCLES (D),
        .LZB_EN      (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value       (value),
        .load        (load),
        .nibble      (nibble),
        .digit_en_n  (digit_en_n),
        .frame_start (frame_start)
    );

    typedef struct {
        int         cyc;
        logic [3:0] nib;
        logic [3:0] en;
        logic       fs;
    } exp_t;

    typedef struct {
        int          cyc;
        logic [15:0] val;
    } load_t;

    exp_t  exp_q[$];
    load_t load_log[$];
    int    cyc;
    int    n_checks = 0;
    int    n_fail   = 0;
    exp_t  mon_e;

    // Value on display during frame f: the latest load made before that frame's opening tick.
    function automatic logic [15:0] disp_of(int f);
        logic [15:0] d;
        d = '0;
        if (f == 0) return d;
        foreach (load_log[k]) begin
            if (load_log[k].cyc < f * NR - 1) d = load_log[k].val;
        end
        return d;
    endfunction

    // Expected outputs at cycle c counted from reset release.
    function automatic exp_t model(int c);
        exp_t        e;
        logic [15:0] d;
        logic [15:0] dp;
        logic [3:0]  one;
        int          pos;
        int          dig;
        int          pdig;
        bit          lit;
        e.cyc = c;
        pos   = c % R;
        dig   = (c / R) % N;
        d     = disp_of(c / NR);
        lit   = (dig == 0) || ((d >> (4 * dig)) != 16'h0);
        one   = 4'b0001;
        e.en  = (pos >= D && lit) ? ~(one << dig) : 4'hF;
        if (c == 0) begin
            e.nib = 4'h0;
        end else begin
            dp    = disp_of((c - 1) / NR);
            pdig  = ((c - 1) / R) % N;
            e.nib = dp[pdig*4 +: 4];
        end
        e.fs = (c > 0) && (c % NR == 0);
        return e;
    endfunction

    task automatic chk(input string name, input int c, input logic [3:0] act, input logic [3:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, want);
        end
    endtask

    // Monitor: compare the DUT outputs against each queued expectation mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("nibble", mon_e.cyc, nibble, mon_e.nib);
            chk("digit_en_n", mon_e.cyc, digit_en_n, mon_e.en);
            chk("frame_start", mon_e.cyc, {3'b000, frame_start}, {3'b000, mon_e.fs});
        end
    end

    task automatic step(input bit ld, input logic [15:0] v);
        exp_q.push_back(model(cyc));
        load  = ld;
        value = v;
        if (ld) load_log.push_back('{cyc: cyc, val: v});
        @(posedge clk);
        #1;
        load = 1'b0;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, value);
    endtask

    task automatic wait_pos(input int p);
        while (cyc % NR != p) step(1'b0, value);
    endtask

    task automatic do_reset(input int n);
        exp_t e;
        e.cyc = -1;
        e.nib = 4'h0;
        e.en  = 4'hF;
        e.fs  = 1'b0;
        rst_n = 1'b0;
        load  = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (i < n - 1) exp_q.push_back(e);
        end
        rst_n = 1'b1;
        cyc   = 0;
        load_log.delete();
    endtask

    initial begin
        logic [15:0] v;
        int          gap;

        do_reset(3);
        idle(2 * NR);

        // Plain scan of a full value.
        step(1'b1, 16'h1234);
        idle(2 * NR);

        // Mid-frame load must not tear the current frame.
        wait_pos(10);
        step(1'b1, 16'hABCD);
        idle(2 * NR);

        // Load landing exactly on the frame-boundary tick while another is pending.
        wait_pos(5);
        step(1'b1, 16'h1111);
        wait_pos(NR - 1);
        step(1'b1, 16'h5555);
        idle(3 * NR);

        // Leading-zero blanking.
        wait_pos(3);
        step(1'b1, 16'h0070);
        idle(2 * NR);
        step(1'b1, 16'h0000);
        idle(2 * NR);

        // Back-to-back loads: last one wins.
        step(1'b1, 16'h00F0);
        step(1'b1, 16'h0300);
        step(1'b1, 16'h4000);
        idle(2 * NR);

        // Random loads with a mix of leading-zero widths.
        for (int k = 0; k < 30; k++) begin
            gap = int'($urandom_range(0, 40));
            idle(gap);
            v = 16'($urandom);
            case ($urandom_range(0, 3))
                0: v = v & 16'h000F;
                1: v = v & 16'h00FF;
                2: v = v & 16'h0FFF;
                default: v = v;
            endcase
            step(1'b1, v);
        end
        idle(2 * NR);

        // Reset during digit 2's slot with a load still pending.
        wait_pos(2 * R + 3);
        step(1'b1, 16'h9876);
        idle(1);
        do_reset(2);
        idle(2 * NR);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
